// File: rtl/result_frame_uart_tx.sv
// rtl/result_frame_uart_tx.sv - result frame framer and 8N1 UART transmitter
//
// Purpose:
//   Captures exp_sel and logic_output when start is accepted. Sends the frame
//   HDR_BYTE, exp_sel, logic_output[15:8], logic_output[7:0], TAIL_BYTE
//   on TXD as 8N1 characters, LSB first, DIV = CLK_FREQ/BAUD clocks per bit.
//   The bytes of one frame are sent back to back, with no idle gap.
//
// Optional feature:
//   RESULT_FRAME_CHECKSUM_EN - when this macro is defined, a checksum byte
//   (exp_sel ^ logic_output[15:8] ^ logic_output[7:0]) is inserted before
//   TAIL_BYTE. The frame is then 6 bytes long.
//
// Ports:
//   tclk          in   system clock, rising edge
//   rst           in   synchronous reset, active-high
//   start         in   frame request, sampled only while busy=0
//   exp_sel       in   [7:0]  experiment code, sent in byte 1
//   logic_output  in   [15:0] experiment result, sent in bytes 2 and 3
//   TXD           out  serial line, idle high, registered
//   busy          out  high while a frame is in flight
//   done          out  one-cycle pulse when the last stop bit ends

module result_frame_uart_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter logic [7:0]  HDR_BYTE  = 8'hAA,
  parameter logic [7:0]  TAIL_BYTE = 8'h55
) (
  input  logic        tclk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  exp_sel,
  input  logic [15:0] logic_output,
  output logic        TXD,
  output logic        busy,
  output logic        done
);

  localparam int unsigned DIV       = CLK_FREQ / BAUD;
  localparam int          CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

`ifdef RESULT_FRAME_CHECKSUM_EN
  localparam int NBYTES = 6;
`else
  localparam int NBYTES = 5;
`endif
  localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [2:0]    byte_idx, idx_n;
  logic          txd_q, txd_n;
  logic          done_q, done_n;

  logic [7:0]    buf_sel, buf_hi, buf_lo;
  logic [7:0]    cur_byte;
  logic          accept;
  logic          bit_end;

  assign accept  = (state == S_IDLE) && start;
  assign bit_end = (baud_cnt == BAUD_LAST);

  assign TXD  = txd_q;
  assign done = done_q;
  assign busy = (state != S_IDLE);

  // Byte selected by the next index, so TXD can be registered together with
  // the state. Frame buffer contents are stable before any data bit is sent.
  always_comb begin
    cur_byte = TAIL_BYTE;
    case (idx_n)
      3'd0:    cur_byte = HDR_BYTE;
      3'd1:    cur_byte = buf_sel;
      3'd2:    cur_byte = buf_hi;
      3'd3:    cur_byte = buf_lo;
`ifdef RESULT_FRAME_CHECKSUM_EN
      3'd4:    cur_byte = buf_sel ^ buf_hi ^ buf_lo;
      3'd5:    cur_byte = TAIL_BYTE;
`else
      3'd4:    cur_byte = TAIL_BYTE;
`endif
      default: cur_byte = TAIL_BYTE;
    endcase
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    idx_n   = byte_idx;
    done_n  = 1'b0;
    txd_n   = 1'b1;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_START;
          baud_n  = '0;
          bit_n   = '0;
          idx_n   = '0;
        end
      end

      S_START: begin
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (bit_cnt == 3'd7) begin
            bit_n   = '0;
            state_n = S_STOP;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          baud_n = '0;
          if (byte_idx < LAST_IDX) begin
            // Next byte starts immediately: no idle gap inside a frame.
            idx_n   = byte_idx + 1'b1;
            state_n = S_START;
          end else begin
            idx_n   = '0;
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        idx_n   = '0;
      end
    endcase

    case (state_n)
      S_START: txd_n = 1'b0;
      S_DATA:  txd_n = cur_byte[bit_n];
      default: txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge tclk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
      buf_sel  <= '0;
      buf_hi   <= '0;
      buf_lo   <= '0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      byte_idx <= idx_n;
      txd_q    <= txd_n;
      done_q   <= done_n;
      if (accept) begin
        buf_sel <= exp_sel;
        buf_hi  <= logic_output[15:8];
        buf_lo  <= logic_output[7:0];
      end
    end
  end

endmodule
